// File: rtl/branch_pkg.sv
// Shared types for the branch predict unit: branch condition codes, 2-bit
// history counter states, and the saturating counter step.
package branch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_state_e;

    // Counters stick at the strong states instead of wrapping around.
    function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CNT_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator; flags the two undefined
// func_3 encodings as illegal and never reports them as taken.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      func_3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func_3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor (2-bit counter table) with execute-stage branch
// resolution. Define BRANCH_STATS_EN to add branch/mispredict counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     pc_f,
    output logic            predict_taken_f,
    input  logic            en_e,
    input  logic            stall_e,
    input  logic [2:0]      func_3_e,
    input  logic [31:0]     pc_e,
    input  logic [XLEN-1:0] rs1_e,
    input  logic [XLEN-1:0] rs2_e,
    input  logic            pred_taken_e,
    output logic            taken_e,
    output logic            mispredict_e,
    output logic            illegal_e
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       cnt_q [BHT_DEPTH];
    logic [1:0]       cnt_d [BHT_DEPTH];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic             cmp_taken;
    logic             cmp_illegal;
    logic             update;
    logic             unused_pc_bits;

    branch_compare #(.XLEN(XLEN)) u_compare (
        .rs1     (rs1_e),
        .rs2     (rs2_e),
        .func_3  (func_3_e),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign idx_f          = pc_f[IDX_W+1:2];
    assign idx_e          = pc_e[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_f[31:IDX_W+2], pc_f[1:0], pc_e[31:IDX_W+2], pc_e[1:0]};

    assign illegal_e       = en_e & cmp_illegal;
    assign taken_e         = en_e & ~cmp_illegal & cmp_taken;
    assign mispredict_e    = en_e & ~cmp_illegal & (taken_e != pred_taken_e);
    assign update          = en_e & ~stall_e & ~cmp_illegal;
    assign predict_taken_f = cnt_q[idx_f][1];

    always_comb begin
        cnt_d = cnt_q;
        if (update) cnt_d[idx_e] = cnt_next(cnt_q[idx_e], taken_e);
    end

    // Reset wins over a same-edge update so no partial table state survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CNT_WNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] mispredict_cnt_q;
    logic [31:0] mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (mispredict_e) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: a table of combinational
// compare vectors plus hand-written sequences for counter/stall/reset behaviour.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic        predict_taken_f;
    logic        en_e;
    logic        stall_e;
    logic [2:0]  func_3_e;
    logic [31:0] pc_e;
    logic [31:0] rs1_e;
    logic [31:0] rs2_e;
    logic        pred_taken_e;
    logic        taken_e;
    logic        mispredict_e;
    logic        illegal_e;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
`endif

    int checks;
    int passes;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
        logic        en;
        logic        exp_taken;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[16];

    branch_predict_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_f            (pc_f),
        .predict_taken_f (predict_taken_f),
        .en_e            (en_e),
        .stall_e         (stall_e),
        .func_3_e        (func_3_e),
        .pc_e            (pc_e),
        .rs1_e           (rs1_e),
        .rs2_e           (rs2_e),
        .pred_taken_e    (pred_taken_e),
        .taken_e         (taken_e),
        .mispredict_e    (mispredict_e),
        .illegal_e       (illegal_e)
`ifdef BRANCH_STATS_EN
        ,
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic en, input logic stall, input logic [2:0] f3,
                                 input logic [31:0] pce, input logic [31:0] a,
                                 input logic [31:0] b, input logic pred);
        en_e         = en;
        stall_e      = stall;
        func_3_e     = f3;
        pc_e         = pce;
        rs1_e        = a;
        rs2_e        = b;
        pred_taken_e = pred;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic checkPredict(input string name, input logic [31:0] pc, input logic expected);
        pc_f = pc;
        #1;
        checkOutput(name, {31'd0, predict_taken_f}, {31'd0, expected});
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        pc_f   = 32'h0;
        idle();

        vecs[0]  = '{3'b000, 32'h5,        32'h5,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b000, 32'h5,        32'h6,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 32'h5,        32'h6,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'b110, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b101, 32'hFFFFFFFF, 32'h1,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b111, 32'hFFFFFFFF, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 32'h1,        32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 32'h1,        32'h1,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{3'b110, 32'h1,        32'h2,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 32'h7,        32'h7,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b011, 32'h5,        32'h5,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b010, 32'h5,        32'h5,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b000, 32'h5,        32'h5,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{3'b110, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        tick();
        tick();
        rst = 1'b0;

        // Every entry comes out of reset weakly not-taken.
        for (int i = 0; i < 16; i++) checkPredict($sformatf("reset_predict_%0d", i), i * 4, 1'b0);
        checkPredict("reset_predict_0x40", 32'h40, 1'b0);

        // Compare vectors run stalled so the table is left alone.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].en, 1'b1, vecs[i].f3, 32'h40, vecs[i].rs1, vecs[i].rs2, vecs[i].pred);
            checkOutput($sformatf("vec%0d_taken", i), {31'd0, taken_e}, {31'd0, vecs[i].exp_taken});
            checkOutput($sformatf("vec%0d_mispredict", i), {31'd0, mispredict_e}, {31'd0, vecs[i].exp_mis});
            checkOutput($sformatf("vec%0d_illegal", i), {31'd0, illegal_e}, {31'd0, vecs[i].exp_ill});
        end
        idle();
        tick();
        checkPredict("stalled_vectors_no_update", 32'h40, 1'b0);

        // Taken BEQ at 0x40: WNT -> WT -> ST -> ST, then two not-taken: WT -> WNT.
        pc_f = 32'h40;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h40, 32'h5, 32'h5, 1'b0);
        checkOutput("beq1_taken", {31'd0, taken_e}, 32'd1);
        checkOutput("beq1_mispredict", {31'd0, mispredict_e}, 32'd1);
        tick();
        checkPredict("after_beq1_wt", 32'h40, 1'b1);
        checkOutput("beq2_mispredict", {31'd0, mispredict_e}, 32'd1);
        tick();
        tick();
        idle();
        checkPredict("after_beq3_st", 32'h40, 1'b1);
        checkPredict("alias_0x00", 32'h00, 1'b1);
        checkPredict("neighbour_0x44", 32'h44, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h40, 32'h5, 32'h6, 1'b1);
        checkOutput("nt1_mispredict", {31'd0, mispredict_e}, 32'd1);
        tick();
        checkPredict("saturated_then_wt", 32'h40, 1'b1);
        tick();
        idle();
        checkPredict("back_to_wnt", 32'h40, 1'b0);

        // Same-cycle lookup/update at 0x44 returns the pre-update counter.
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h44, 32'h5, 32'h5, 1'b0);
        tick();
        pc_f = 32'h44;
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h44, 32'h5, 32'h5, 1'b1);
        checkPredict("bypass_pre_update", 32'h44, 1'b1);
        checkOutput("bypass_taken", {31'd0, taken_e}, 32'd0);
        checkOutput("bypass_mispredict", {31'd0, mispredict_e}, 32'd1);
        tick();
        idle();
        checkPredict("bypass_post_update", 32'h44, 1'b0);

        // Illegal branch at 0x48 must not touch the counter; one taken then lands at WT.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h48, 32'h5, 32'h6, 1'b1);
        checkOutput("illegal_flag", {31'd0, illegal_e}, 32'd1);
        checkOutput("illegal_taken", {31'd0, taken_e}, 32'd0);
        checkOutput("illegal_mispredict", {31'd0, mispredict_e}, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h48, 32'h5, 32'h5, 1'b0);
        tick();
        idle();
        checkPredict("illegal_left_table", 32'h48, 1'b1);

        // Branch at 0x4C held for three stall cycles updates exactly once.
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h4C, 32'h5, 32'h5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkPredict($sformatf("stall_cycle_%0d", i), 32'h4C, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h4C, 32'h5, 32'h5, 1'b0);
        tick();
        idle();
        checkPredict("stall_release_update", 32'h4C, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h4C, 32'h5, 32'h6, 1'b1);
        tick();
        idle();
        checkPredict("stall_single_update", 32'h4C, 1'b0);

        // Reset overrides a same-edge update; outputs still follow inputs under reset.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h48, 32'h5, 32'h5, 1'b0);
        checkOutput("reset_taken_follows", {31'd0, taken_e}, 32'd1);
        checkOutput("reset_mispredict_follows", {31'd0, mispredict_e}, 32'd1);
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) checkPredict($sformatf("midreset_predict_%0d", i), 32'h40 + i * 4, 1'b0);

`ifdef BRANCH_STATS_EN
        checkOutput("stats_reset_branch", branch_cnt, 32'd0);
        checkOutput("stats_reset_mispredict", mispredict_cnt, 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 3'b000, 32'h40, 32'h1, 32'h1, (i < 3) ? 1'b0 : 1'b1);
            tick();
            applyStimulus(1'b1, 1'b1, 3'b000, 32'h40, 32'h1, 32'h1, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h40, 32'h1, 32'h2, 1'b0);
        tick();
        idle();
        checkOutput("stats_branch_cnt", branch_cnt, 32'd10);
        checkOutput("stats_mispredict_cnt", mispredict_cnt, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("stats_cleared_branch", branch_cnt, 32'd0);
        checkOutput("stats_cleared_mispredict", mispredict_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
